// File: rtl/stream_mux_rr.sv
// N_CH:1 stream multiplexer with fixed-select or round-robin grant and a registered output beat.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_last,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_ch,
  input  logic                out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand_idx;
  logic             gnt_vld;
  logic [W-1:0]     gnt_data;
  logic             gnt_last;
  logic             load;
  logic             xfer;
  logic             lock_act;
  logic [SEL_W-1:0] lock_ch;

  assign load = ~out_valid | out_ready;

  // Round-robin scans from the farthest candidate down so the nearest one after rr_ptr wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (lock_act) begin
      gnt_vld = in_valid[lock_ch];
      gnt_idx = lock_ch;
    end else if (!mode) begin
      if (int'(sel) < N_CH) begin
        gnt_vld = in_valid[sel];
        gnt_idx = sel;
      end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        cand_idx = SEL_W'((int'(rr_ptr) + k) % N_CH);
        if (in_valid[cand_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = in_data[i*W +: W];
        gnt_last = in_last[i];
      end
      in_ready[i] = rst_n & load & gnt_vld & (gnt_idx == SEL_W'(i));
    end
  end

  assign xfer = |in_ready;

  // Output beat register: loads on a transfer, clears when drained with nothing new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gnt_data;
        out_last <= gnt_last;
        out_ch   <= gnt_idx;
        if (mode) rr_ptr <= gnt_idx;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_act <= 1'b0;
      lock_ch  <= '0;
    end else if (xfer) begin
      lock_act <= ~gnt_last;
      lock_ch  <= gnt_idx;
    end
  end
`else
  assign lock_act = 1'b0;
  assign lock_ch  = '0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus randomized traffic against a priority-list model.
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SW-1:0]   out_ch;
  logic            out_ready = 1'b0;

  logic            mode3 = 1'b0;
  logic [1:0]      sel3 = '0;
  logic [2:0]      in_valid3 = '0;
  logic [23:0]     in_data3 = '0;
  logic [2:0]      in_last3 = '0;
  logic [2:0]      in_ready3;
  logic            out_valid3;
  logic [W-1:0]    out_data3;
  logic            out_last3;
  logic [1:0]      out_ch3;
  logic            out_ready3 = 1'b0;

  stream_mux_rr #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit         m_valid = 1'b0;
  bit         m_last = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_ch = 0;
  int         m_ptr = N - 1;
  bit         m_lock = 1'b0;
  int         m_lock_ch = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit vld_of(input int c);
    return ((in_valid >> c) & N'(1)) != '0;
  endfunction

  // Ordered list of channels eligible this cycle; the first valid one wins.
  function automatic int model_grant();
    int order[$];
    if (m_lock) order.push_back(m_lock_ch);
    else if (!mode) begin
      if (int'(sel) < N) order.push_back(int'(sel));
    end else begin
      for (int k = 1; k <= N; k++) order.push_back((m_ptr + k) % N);
    end
    foreach (order[i]) if (vld_of(order[i])) return order[i];
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g;
    bit ld;
    #1;
    ld = !m_valid || out_ready;
    g = model_grant();
    exp_rdy = '0;
    if (rst_n && ld && g >= 0) exp_rdy = N'(1) << g;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_ch = 0; m_ptr = N - 1;
      m_lock = 1'b0; m_lock_ch = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = W'(in_data >> (g * W));
        m_last  = ((in_last >> g) & N'(1)) != '0;
        m_ch    = g;
        if (mode) m_ptr = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_lock    = !m_last;
        m_lock_ch = g;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_last", 64'(out_last), 64'(m_last));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]  hold_data;
    logic [SW-1:0] hold_ch;
    int exp6[4];

    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '1;
    cycle();
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);

    // Fixed select: ch0=1, ch1=0, ch2=1, ch3=0
    rst_n = 1'b1; mode = 1'b0; out_ready = 1'b1; in_last = '1;
    in_data = {8'h00, 8'h01, 8'h00, 8'h01};
    for (int s = 0; s < 4; s++) begin
      sel = SW'(s);
      repeat (3) cycle();
      chk("fixed_data", 64'(out_data), (s % 2 == 0) ? 64'd1 : 64'd0);
      chk("fixed_ch", 64'(out_ch), 64'(s));
    end

    // Round-robin, pointer still at reset value because fixed mode leaves it alone
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = (N*W)'($urandom);
      cycle();
      chk("rr_all", 64'(out_ch), 64'(k % 4));
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_data = (N*W)'($urandom);
      cycle();
      chk("rr_1010", 64'(out_ch), (k % 2 == 0) ? 64'd3 : 64'd1);
    end

    // Backpressure
    in_valid = '1;
    cycle();
    out_ready = 1'b0;
    hold_data = out_data;
    hold_ch = out_ch;
    for (int k = 0; k < 5; k++) begin
      in_data = (N*W)'($urandom);
      cycle();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(hold_data));
      chk("stall_ch", 64'(out_ch), 64'(hold_ch));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = (N*W)'($urandom);
      cycle();
    end

    // Reset while a beat is held
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    cycle();
    chk("post_rst_ch", 64'(out_ch), 64'd0);

    // Packet on ch0 while ch1 competes
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp6 = '{0, 0, 0, 1};
`else
    exp6 = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    in_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      in_last = {3'b001, (k == 2) ? 1'b1 : 1'b0};
      in_data = (N*W)'($urandom);
      cycle();
      chk("pkt_seq", 64'(out_ch), 64'(exp6[k]));
    end

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      in_last   = N'($urandom) | N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst_n = 1'b1;

    // Out-of-range select on a 3-channel instance
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111;
    in_data3 = {8'h33, 8'h22, 8'h11}; out_ready3 = 1'b0;
    @(posedge clk); #1;
    chk("n3_load_valid", 64'(out_valid3), 64'd1);
    chk("n3_load_data", 64'(out_data3), 64'h11);
    @(negedge clk);
    sel3 = 2'd3; out_ready3 = 1'b1;
    #1;
    chk("n3_oor_ready", 64'(in_ready3), 64'd0);
    @(posedge clk); #1;
    chk("n3_drain_valid", 64'(out_valid3), 64'd0);
    @(posedge clk); #1;
    chk("n3_idle_valid", 64'(out_valid3), 64'd0);
    chk("n3_hold_data", 64'(out_data3), 64'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised successor to the team's 4:1 bit multiplexer. Selects one of N_CH W-bit input streams onto a single registered output stream with valid/ready handshakes. It supports two modes: fixed select and round-robin arbitration. It sits between multiple producer channels and one shared consumer, for example a shared bus or a dump/monitor port.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (1..64).
- SEL_W, $clog2(N_CH), width of sel and out_ch. Derived; not overridden by the instantiator.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
- in_last  input  N_CH  per-channel end-of-packet marker.
- in_ready  output  N_CH  per-channel ready (combinational).
- out_valid  output  1  output beat valid (registered).
- out_data  output  W  output data (registered).
- out_last  output  1  end-of-packet marker of the output beat (registered).
- out_ch  output  SEL_W  source channel of the output beat (registered).
- out_ready  input  1  consumer ready.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low, sampled on the rising edge of `clk`.
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=N_CH-1. While rst_n=0, in_ready=0.
- Transfer rule: an input transfer occurs when in_valid[i] & in_ready[i]. An output transfer occurs when out_valid & out_ready.
- Load condition: load = ~out_valid | out_ready. This gives full throughput of one beat per cycle.
- Grant: grant is one-hot (or zero) and combinational from in_valid, mode, sel, rr_ptr and the lock state. in_ready[i] = grant[i] & load. At most one bit of in_ready is set.
- Fixed mode (mode=0): grant[sel] = in_valid[sel]. If sel >= N_CH, no grant and in_ready=0. Other channels are stalled.
- Round-robin mode (mode=1): search channels rr_ptr+1, rr_ptr+2, … modulo N_CH and grant the first with in_valid=1. rr_ptr updates to the granted index only on an input transfer. With rr_ptr at reset, channel 0 has first priority.
- On an input transfer: out_data, out_last and out_ch are loaded from the granted channel, and out_valid=1 on the next cycle. Latency is 1 cycle from input transfer to out_valid.
- Output clear: if out_ready=1 with no new grant, out_valid is cleared to 0 on the next edge. out_data holds its last value.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and the output registers hold stable. Data must not change while valid is held.
- Mode or sel change: takes effect at the next grant evaluation. The beat already in the output register is unaffected. rr_ptr is retained across mode changes.
- No valid inputs: grant=0, no transfer. rr_ptr is unchanged.
- Reset mid-operation: any pending output beat is dropped and all state returns to reset values on the edge where rst_n=0.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined: packet lock. After an input transfer with in_last=0, grant is locked to that channel regardless of mode, sel or rr_ptr. The lock lasts until a transfer with in_last=1 from that channel. While locked, an invalid locked channel stalls the mux; other channels are not granted. The lock register resets to unlocked.
- Not defined: per-beat arbitration. in_last is passed through to out_last only and never influences grant.

Test Plan:
1. Reset and fixed select, W=1, N_CH=4.
   - Stimulus: rst_n=0 for 2 cycles; then in_data={0,1,0,1} (ch0=1, ch1=0, ch2=1, ch3=0), all in_valid=1, out_ready=1, mode=0; sel stepped 0,1,2,3 every 10 cycles.
   - Response: out_data=1,0,1,0 with out_ch=sel one cycle after each step; during reset all outputs are 0.
2. Round-robin fairness, N_CH=4.
   - Stimulus: mode=1, all in_valid=1, out_ready=1.
   - Response: out_ch sequence 0,1,2,3,0,1, one beat per cycle. With only in_valid=4'b1010: 1,3,1,3.
3. Backpressure.
   - Stimulus: mode=1; out_ready=0 for 5 cycles after the first beat.
   - Response: out_valid=1, out_data/out_ch stable, in_ready=0 throughout the stall. Transfers resume the cycle after out_ready=1 with no lost or duplicated beats.
4. Out-of-range sel, N_CH=3.
   - Stimulus: mode=0, sel=3, all valid.
   - Response: in_ready=0, out_valid falls to 0 after the pending beat drains.
5. Reset mid-stream.
   - Stimulus: rst_n=0 for 1 cycle while out_valid=1 and out_ready=0.
   - Response: next cycle out_valid=0; rr_ptr restored, so the next round-robin grant is ch0.
6. Packet lock (STREAM_MUX_PKT_LOCK_EN defined).
   - Stimulus: mode=1; ch0 sends 3 beats with in_last=0,0,1 while ch1 is valid.
   - Response: out_ch=0,0,0, then 1. Without the macro: 0,1,0,1…
